// File: rtl/pic10_cycle_sequencer.sv
// Instruction-cycle controller for the pic10 datapath: start-up delay, fetch/execute pipeline, flushes, SLEEP/wake.
// Strobes are combinational from seq_state and inputs; stall freezes everything and forces all strobes low.
module pic10_cycle_sequencer #(
    parameter int STARTUP_CYCLES = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             dec_goto,
    input  logic             dec_skip,
    input  logic             skip_true,
    input  logic             dec_sleep,
    input  logic             wake,
    output logic             load_ir_reg,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ir_flush,
    output logic             exec_en,
    output logic [2:0]       seq_state,
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [2:0] ST_STARTUP = 3'd0;
    localparam logic [2:0] ST_FETCH0  = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_SLEEP   = 3'd4;
    localparam logic [2:0] ST_RESET   = (STARTUP_CYCLES == 0) ? ST_FETCH0 : ST_STARTUP;

    localparam int            SU_W    = (STARTUP_CYCLES > 2) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [SU_W-1:0] SU_LAST = (STARTUP_CYCLES == 0) ? '0 : SU_W'(STARTUP_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [SU_W-1:0]  su_cnt_q, su_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld, inc, pcl, fl, ex;

    always_comb begin
        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        cnt_d    = cnt_q;
        ld       = 1'b0;
        inc      = 1'b0;
        pcl      = 1'b0;
        fl       = 1'b0;
        ex       = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_STARTUP: begin
                    if (STARTUP_CYCLES == 0 || su_cnt_q == SU_LAST) begin
                        state_d  = ST_FETCH0;
                        su_cnt_d = '0;
                    end else begin
                        su_cnt_d = su_cnt_q + 1'b1;
                    end
                end
                ST_FETCH0: begin
                    ld      = 1'b1;
                    inc     = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    ex = 1'b1;
                    if (dec_sleep) begin
                        state_d = ST_SLEEP;
                    end else if (dec_goto) begin
                        pcl     = 1'b1;
                        fl      = 1'b1;
                        state_d = ST_FLUSH;
                    end else if (dec_skip && skip_true) begin
                        // Skip advances PC past the prefetched word and discards it.
                        inc     = 1'b1;
                        fl      = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        ld  = 1'b1;
                        inc = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    ld      = 1'b1;
                    inc     = 1'b1;
                    state_d = ST_RUN;
                end
                ST_SLEEP: begin
                    if (wake) begin
                        state_d = ST_FLUSH;
                    end
                end
                default: begin
                    state_d  = ST_STARTUP;
                    su_cnt_d = '0;
                end
            endcase
            if (ex) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RESET;
            su_cnt_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            su_cnt_q <= su_cnt_d;
            cnt_q    <= cnt_d;
        end
    end

    // Gate with reset so a zero-delay start-up state cannot strobe while held in reset.
    assign load_ir_reg = ld  & reset;
    assign pc_inc      = inc & reset;
    assign pc_load     = pcl & reset;
    assign ir_flush    = fl  & reset;
    assign exec_en     = ex  & reset;
    assign seq_state   = state_q;
    assign inst_count  = cnt_q;

endmodule

// File: tb/tb_pic10_cycle_sequencer.sv
// Scoreboard bench: driver pushes per-cycle expectations from a pipeline-level model; monitor pops and compares.
module tb_pic10_cycle_sequencer;

    localparam int STARTUP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        dec_goto = 1'b0;
    logic        dec_skip = 1'b0;
    logic        skip_true = 1'b0;
    logic        dec_sleep = 1'b0;
    logic        wake = 1'b0;
    logic        load_ir_reg, pc_inc, pc_load, ir_flush, exec_en;
    logic [2:0]  seq_state;
    logic [15:0] inst_count;

    pic10_cycle_sequencer #(.STARTUP_CYCLES(STARTUP), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .dec_goto   (dec_goto),
        .dec_skip   (dec_skip),
        .skip_true  (skip_true),
        .dec_sleep  (dec_sleep),
        .wake       (wake),
        .load_ir_reg(load_ir_reg),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .ir_flush   (ir_flush),
        .exec_en    (exec_en),
        .seq_state  (seq_state),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ld;
        logic        inc;
        logic        pcl;
        logic        fl;
        logic        ex;
        logic [2:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Pipeline-level model: what the IR holds and where the core is in its life.
    int          startup_left = STARTUP;
    bit          primed   = 1'b0;
    bit          asleep   = 1'b0;
    bit          ir_valid = 1'b0;
    int unsigned mcount   = 0;

    task automatic cyc(input bit r, input bit st, input bit g, input bit sk,
                       input bit skt, input bit sl, input bit wk);
        exp_t e;
        @(negedge clk);
        reset = r; stall = st; dec_goto = g; dec_skip = sk;
        skip_true = skt; dec_sleep = sl; wake = wk;
        e = '0;
        if (!r) begin
            startup_left = STARTUP; primed = 1'b0; asleep = 1'b0;
            ir_valid = 1'b0; mcount = 0;
        end else begin
            e.cnt = mcount[15:0];
            if (startup_left > 0)  e.st = 3'd0;
            else if (!primed)      e.st = 3'd1;
            else if (asleep)       e.st = 3'd4;
            else if (ir_valid)     e.st = 3'd2;
            else                   e.st = 3'd3;
            if (!st) begin
                if (startup_left > 0) begin
                    startup_left--;
                end else if (!primed) begin
                    e.ld = 1'b1; e.inc = 1'b1; primed = 1'b1; ir_valid = 1'b1;
                end else if (asleep) begin
                    if (wk) begin asleep = 1'b0; ir_valid = 1'b0; end
                end else if (!ir_valid) begin
                    e.ld = 1'b1; e.inc = 1'b1; ir_valid = 1'b1;
                end else begin
                    e.ex = 1'b1;
                    mcount = (mcount + 1) % 65536;
                    if (sl)              asleep = 1'b1;
                    else if (g)          begin e.pcl = 1'b1; e.fl = 1'b1; ir_valid = 1'b0; end
                    else if (sk && skt)  begin e.inc = 1'b1; e.fl = 1'b1; ir_valid = 1'b0; end
                    else                 begin e.ld = 1'b1; e.inc = 1'b1; end
                end
            end
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            #2;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {load_ir_reg, pc_inc, pc_load, ir_flush, exec_en, seq_state, inst_count};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle%0d ld/inc/pcl/fl/ex/st/cnt got %b%b%b%b%b/%0d/%h want %b%b%b%b%b/%0d/%h",
                             cycle, a.ld, a.inc, a.pcl, a.fl, a.ex, a.st, a.cnt,
                             e.ld, e.inc, e.pcl, e.fl, e.ex, e.st, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (STARTUP + 1) cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);            // goto
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);            // skip not taken
        cyc(1, 0, 0, 1, 1, 0, 0);            // skip taken
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, 0, 0);            // goto beats skip
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);            // sleep
        repeat (20) cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 1); // wake while stalled
        cyc(1, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 1, 0, 0, 1, 0); // stall in RUN
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 1) == 1, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) == 0));
        end

        // Counter wrap: 65534 straight-line instructions, then three more.
        cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (STARTUP + 1) cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (65534 + 3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);            // goto -> FLUSH next
        cyc(0, 0, 0, 0, 0, 0, 0);            // reset lands mid-FLUSH
        cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (STARTUP + 3) cyc(1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
